sm_icache: RTL and testbench

//   Direct-mapped, one-word-per-line instruction cache between the core's

---
 rtl/sm_icache.sv | 122 ++++++++++++
 tb/tb_sm_icache.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_icache.sv
// Direct-mapped, one-word-per-line instruction cache with a req/ack refill port.
// cpuEn doubles as the core's advance enable: it is high only on a hit in IDLE.
module sm_icache #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       cpuAddr,
   output logic [31:0]       cpuData,
   output logic              cpuEn,
   input  logic              flush,
   output logic              memReq,
   output logic [31:0]       memAddr,
   input  logic              memAck,
   input  logic [31:0]       memData,
   output logic [CNT_W-1:0]  missCount
);

   localparam int unsigned LINES = 32'd1 << IDX_W;
   localparam int unsigned TAG_W = 32 - IDX_W;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
   logic                flush_pend_q, flush_pend_d;
   logic [LINES-1:0]    valid_q, valid_d;

   // Data and tag arrays are never reset; only the valid bits are.
   logic [31:0]         data_mem [LINES];
   logic [TAG_W-1:0]    tag_mem  [LINES];

   logic [IDX_W-1:0]    cpu_idx;
   logic [IDX_W-1:0]    fill_idx;
   logic                hit_c;
   logic                fill_done_c;

   assign cpu_idx     = cpuAddr[IDX_W-1:0];
   assign fill_idx    = mem_addr_q[IDX_W-1:0];
   assign hit_c       = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpuAddr[31:IDX_W]);
   assign fill_done_c = (state_q == S_FILL) && memAck;

   assign cpuData   = data_mem[cpu_idx];
   assign cpuEn     = hit_c && (state_q == S_IDLE);
   assign memReq    = mem_req_q;
   assign memAddr   = mem_addr_q;
   assign missCount = miss_cnt_q;

   // State and control registers; reset drops memReq immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 32'd0;
         miss_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         miss_cnt_q   <= miss_cnt_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
      end
   end

   // Line write on the acknowledged fill; a late ack after reset cannot reach here.
   always_ff @(posedge clk) begin
      if (fill_done_c) begin
         data_mem[fill_idx] <= memData;
         tag_mem[fill_idx]  <= mem_addr_q[31:IDX_W];
      end
   end

   // Next state: a miss not masked by flush starts a fill, the ack ends it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!flush && !hit_c) state_d = S_FILL;
         S_FILL: if (memAck)           state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   // Register updates for request, address, miss counter, flush latch and valid bits.
   always_comb begin
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      miss_cnt_d   = miss_cnt_q;
      flush_pend_d = flush_pend_q;
      valid_d      = valid_q;
      case (state_q)
         S_IDLE: begin
            flush_pend_d = 1'b0;
            if (flush) begin
               valid_d = '0;
            end else if (!hit_c) begin
               mem_req_d  = 1'b1;
               mem_addr_d = cpuAddr;
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
         end
         S_FILL: begin
            if (flush) flush_pend_d = 1'b1;
            if (memAck) begin
               mem_req_d    = 1'b0;
               flush_pend_d = 1'b0;
               if (flush_pend_q || flush) valid_d = '0;
               else                       valid_d[fill_idx] = 1'b1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sm_icache.sv
// Self-checking bench for sm_icache: directed scenarios plus randomized
// accesses checked against a line-content model of the cache.
module tb_sm_icache;

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = 15;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [31:0]       cpuAddr;
   logic [31:0]       cpuData;
   logic              cpuEn;
   logic              flush;
   logic              memReq;
   logic [31:0]       memAddr;
   logic              memAck;
   logic [31:0]       memData;
   logic [CNT_W-1:0]  missCount;

   int checks = 0;
   int errors = 0;

   // Model: which full word address each line holds, and the miss count.
   bit          m_valid [16];
   logic [31:0] m_addr  [16];
   int          m_cnt;

   sm_icache #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cpuAddr(cpuAddr), .cpuData(cpuData),
      .cpuEn(cpuEn), .flush(flush), .memReq(memReq), .memAddr(memAddr),
      .memAck(memAck), .memData(memData), .missCount(missCount)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Memory image: word stored at each address (address 0 holds 0x24080005).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h24080005;
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      logic [3:0] i;
      i = a[3:0];
      return m_valid[i] && (m_addr[i] == a);
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; memAck = 1'b0; memData = 32'd0; cpuAddr = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (memReq !== 1'b0 || cpuEn !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: memReq=%b cpuEn=%b expected 0 0", memReq, cpuEn);
      end
      checks++;
      if (missCount !== 4'd0 || memAddr !== 32'd0) begin
         errors++; $display("FAIL reset_regs: missCount=%0d memAddr=%h expected 0 0", missCount, memAddr);
      end
      rst_n = 1'b1;
      m_clear();
      m_cnt = 0;
   endtask

   // One lookup of addr; on a miss, serve it with ack delay w, optionally a
   // flush one cycle before the ack, optionally a wandering cpuAddr during FILL.
   // Returns at the negedge of the cycle following the fill (or following the hit).
   task automatic access(input logic [31:0] addr, input int w, input bit fl_in, input bit wander);
      logic [3:0] idx;
      bit fl;
      bit exp_hit;
      idx = addr[3:0];
      fl = fl_in && (w > 0);
      cpuAddr = addr;
      #1;
      if (m_hit(addr)) begin
         checks++;
         if (cpuEn !== 1'b1 || cpuData !== mem_word(addr)) begin
            errors++; $display("FAIL hit %h: cpuEn=%b data=%h expected 1 %h", addr, cpuEn, cpuData, mem_word(addr));
         end
         @(negedge clk);
         checks++;
         if (memReq !== 1'b0) begin
            errors++; $display("FAIL hit_noreq %h: memReq=%b expected 0", addr, memReq);
         end
         return;
      end
      checks++;
      if (cpuEn !== 1'b0) begin
         errors++; $display("FAIL miss_en %h: cpuEn=%b expected 0", addr, cpuEn);
      end
      @(negedge clk);
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      checks++;
      if (memReq !== 1'b1 || memAddr !== addr || missCount !== 4'(m_cnt)) begin
         errors++;
         $display("FAIL miss_start %h: memReq=%b memAddr=%h cnt=%0d expected 1 %h %0d",
                  addr, memReq, memAddr, missCount, addr, m_cnt);
      end
      for (int c = 0; c < w; c++) begin
         flush = (fl && c == w - 1);
         if (wander) cpuAddr = $urandom;
         #1;
         checks++;
         if (cpuEn !== 1'b0 || memReq !== 1'b1 || memAddr !== addr) begin
            errors++;
            $display("FAIL fill_hold %h: cpuEn=%b memReq=%b memAddr=%h expected 0 1 %h",
                     addr, cpuEn, memReq, memAddr, addr);
         end
         @(negedge clk);
      end
      flush = 1'b0;
      memAck = 1'b1;
      memData = mem_word(addr);
      #1;
      checks++;
      if (cpuEn !== 1'b0) begin
         errors++; $display("FAIL ack_en %h: cpuEn=%b expected 0", addr, cpuEn);
      end
      @(negedge clk);
      memAck = 1'b0;
      memData = $urandom;
      cpuAddr = addr;
      if (fl) m_clear();
      else begin
         m_valid[idx] = 1'b1;
         m_addr[idx] = addr;
      end
      exp_hit = m_hit(addr);
      #1;
      checks++;
      if (memReq !== 1'b0 || cpuEn !== exp_hit) begin
         errors++; $display("FAIL fill_end %h: memReq=%b cpuEn=%b expected 0 %b", addr, memReq, cpuEn, exp_hit);
      end
      if (exp_hit) begin
         checks++;
         if (cpuData !== mem_word(addr)) begin
            errors++; $display("FAIL fill_data %h: data=%h expected %h", addr, cpuData, mem_word(addr));
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_cold_start();
      do_reset();
      access(32'h0, 3, 1'b0, 1'b0);
      checks++;
      if (cpuData !== 32'h24080005 || missCount !== 4'd1) begin
         errors++; $display("FAIL cold_start: data=%h cnt=%0d expected 24080005 1", cpuData, missCount);
      end
   endtask

   task automatic test_hit();
      access(32'h0, 2, 1'b0, 1'b0);
      checks++;
      if (missCount !== 4'd1) begin
         errors++; $display("FAIL hit_count: cnt=%0d expected 1", missCount);
      end
   endtask

   task automatic test_conflict();
      do_reset();
      access(32'h3, 2, 1'b0, 1'b0);
      access(32'h13, 1, 1'b0, 1'b0);
      access(32'h3, 2, 1'b0, 1'b0);
      checks++;
      if (missCount !== 4'd3) begin
         errors++; $display("FAIL conflict_count: cnt=%0d expected 3", missCount);
      end
   endtask

   task automatic test_flush_fill();
      do_reset();
      access(32'h5, 3, 1'b1, 1'b0);
      access(32'h5, 2, 1'b0, 1'b0);
      checks++;
      if (missCount !== 4'd2) begin
         errors++; $display("FAIL flush_fill_count: cnt=%0d expected 2", missCount);
      end
   endtask

   task automatic test_flush_idle();
      access(32'h5, 1, 1'b0, 1'b0);
      cpuAddr = 32'h7;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      m_clear();
      #1;
      checks++;
      if (memReq !== 1'b0) begin
         errors++; $display("FAIL flush_priority: memReq=%b expected 0", memReq);
      end
      access(32'h5, 1, 1'b0, 1'b0);
   endtask

   task automatic test_ignored_ack();
      access(32'h9, 1, 1'b0, 1'b0);
      cpuAddr = 32'h9;
      memAck = 1'b1;
      memData = 32'hDEADBEEF;
      @(negedge clk);
      memAck = 1'b0;
      #1;
      checks++;
      if (memReq !== 1'b0 || cpuEn !== 1'b1 || cpuData !== mem_word(32'h9)) begin
         errors++;
         $display("FAIL idle_ack: memReq=%b cpuEn=%b data=%h expected 0 1 %h",
                  memReq, cpuEn, cpuData, mem_word(32'h9));
      end
   endtask

   task automatic test_wrap();
      access(32'hFFFFFFFF, 2, 1'b0, 1'b0);
      access(32'h0000000F, 1, 1'b0, 1'b0);
      access(32'h0, 1, 1'b0, 1'b0);
      access(32'hFFFFFFFF, 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         else a = {28'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
         access(a, int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      end
   endtask

   task automatic test_reset_mid_fill();
      do_reset();
      cpuAddr = 32'h20;
      @(negedge clk);
      checks++;
      if (memReq !== 1'b1) begin
         errors++; $display("FAIL rst_fill_start: memReq=%b expected 1", memReq);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (memReq !== 1'b0 || missCount !== 4'd0) begin
         errors++; $display("FAIL rst_async: memReq=%b cnt=%0d expected 0 0", memReq, missCount);
      end
      memAck = 1'b1;
      memData = 32'h12345678;
      @(negedge clk);
      memAck = 1'b0;
      rst_n = 1'b1;
      m_clear();
      m_cnt = 0;
      flush = 1'b1;
      memAck = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      memAck = 1'b0;
      #1;
      checks++;
      if (memReq !== 1'b0 || cpuEn !== 1'b0 || missCount !== 4'd0) begin
         errors++;
         $display("FAIL late_ack: memReq=%b cpuEn=%b cnt=%0d expected 0 0 0", memReq, cpuEn, missCount);
      end
      access(32'h20, 2, 1'b0, 1'b0);
      checks++;
      if (missCount !== 4'd1) begin
         errors++; $display("FAIL rst_first_miss: cnt=%0d expected 1", missCount);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) access(32'(i), 0, 1'b0, 1'b0);
      checks++;
      if (missCount !== 4'd15) begin
         errors++; $display("FAIL saturation: cnt=%0d expected 15", missCount);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; memAck = 1'b0; memData = 32'd0; cpuAddr = 32'd0;
      @(negedge clk);
      test_reset();
      test_cold_start();
      test_hit();
      test_conflict();
      test_flush_fill();
      test_flush_idle();
      test_ignored_ack();
      test_wrap();
      test_random();
      test_reset_mid_fill();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
